// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and lane type for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    typedef logic [1:0] lane_t;

    function automatic logic f3_valid(input logic store, input logic [2:0] f3);
        if (store)
            return f3 <= F3_W;
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    // Halfword codes share f3[1:0]=01, the word code is 10.
    function automatic logic f3_misaligned(input logic [2:0] f3, input lane_t lane);
        return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and store lane merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  lane_t       lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata[8*lane +: 8];
        rd_half = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_HU:   load_data = {16'h0, rd_half};
            default: load_data = 32'h0;
        endcase

        store_data = wdata;
        if (funct3 == F3_B)
            store_data[8*lane +: 8] = wdata[7:0];
        else if (funct3 == F3_H) begin
            if (lane[1])
                store_data = {wdata[15:0], rdata[15:0]};
            else
                store_data = {rdata[31:16], wdata[15:0]};
        end
        if (funct3 == F3_B) begin
            store_data = rdata;
            store_data[8*lane +: 8] = wdata[7:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store FSM; LSU_MISALIGN_TRAP_EN enables misalignment trapping
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_a,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state, next_state;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        store_q, bad_q, mis_q;
    logic        req_bad, req_mis;
    logic [31:0] load_data, store_data;

    assign req_bad = !f3_valid(req_store, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = !req_bad && f3_misaligned(req_funct3, lane_t'(req_addr[1:0]));
`else
    assign req_mis = 1'b0;
`endif

    lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (lane_t'(addr_q[1:0])),
        .rdata      (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            bad_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                store_q  <= req_store;
                bad_q    <= req_bad;
                mis_q    <= req_mis;
                rdata_q  <= 32'h0;
            end
            if (state == READ)
                rdata_q <= mem_rd;
        end
    end

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_misalign = 1'b0;
        mem_we       = 1'b0;
        mem_wd       = 32'h0;
        mem_a        = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad || req_mis)
                        next_state = RESP;
                    else if (req_store && req_funct3 == F3_W)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ: begin
                mem_a      = {2'b00, addr_q[31:2]};
                next_state = store_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_a      = {2'b00, addr_q[31:2]};
                mem_we     = 1'b1;
                mem_wd     = store_data;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid    = 1'b1;
                rsp_misalign = mis_q;
                if (!store_q && !bad_q && !mis_q)
                    rsp_rdata = load_data;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_a;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = 8'h0;
    logic [31:0] pre_d = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cnt = 0;
    logic [31:0] last_we_a = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          due;
    } exp_t;
    exp_t sb[$];

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_a        (mem_a),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:0]];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we)
            mem[mem_a[7:0]] <= mem_wd;
        else if (pre_we)
            mem[pre_a] <= pre_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            last_we_a = mem_a;
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_misalign", {31'h0, rsp_misalign}, {31'h0, e.mis});
                check("rsp_latency", cyc, e.due);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic request(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic push,
                           input logic [31:0] er, input logic em, input int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (push)
            sb.push_back('{rdata: er, mis: em, due: cyc + lat});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0)
            check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int w0;

    initial begin
        repeat (2) @(negedge clk);
        preload(8'h10, 32'h12345678);
        preload(8'h11, 32'h80FF7F01);
        preload(8'h12, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", {31'h0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_misalign", {31'h0, rsp_misalign}, 32'd0);
        check("reset_mem_we", {31'h0, mem_we}, 32'd0);
        check("reset_mem_wd", mem_wd, 32'h0);
        check("reset_mem_a", mem_a, 32'h0);

        // loads from word 0x11
        w0 = we_cnt;
        request(1'b0, 3'b000, 32'h46, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 2);
        request(1'b0, 3'b101, 32'h46, 32'h0, 1'b1, 32'h000080FF, 1'b0, 2);
        request(1'b0, 3'b001, 32'h46, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, 2);
        request(1'b0, 3'b100, 32'h45, 32'h0, 1'b1, 32'h0000007F, 1'b0, 2);
        request(1'b0, 3'b001, 32'h44, 32'h0, 1'b1, 32'h00007F01, 1'b0, 2);
        request(1'b0, 3'b010, 32'h44, 32'h0, 1'b1, 32'h80FF7F01, 1'b0, 2);
        drain();
        check("loads_no_write", we_cnt - w0, 0);

        // SB / SH read-modify-write
        w0 = we_cnt;
        request(1'b1, 3'b000, 32'h45, 32'h000000AB, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sb_we_count", we_cnt - w0, 1);
        check("sb_mem_a", last_we_a, 32'h11);
        check("sb_mem_word", mem[8'h11], 32'h80FFAB01);
        request(1'b1, 3'b001, 32'h46, 32'h1234CAFE, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sh_mem_word", mem[8'h11], 32'hCAFEAB01);

        // SW
        w0 = we_cnt;
        request(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2);
        drain();
        check("sw_we_count", we_cnt - w0, 1);
        check("sw_mem_word", mem[8'h10], 32'hDEADBEEF);

        // misaligned word load
        w0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        request(1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        request(1'b1, 3'b001, 32'h45, 32'h5555, 1'b1, 32'h0, 1'b1, 1);
`else
        request(1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
        request(1'b0, 3'b101, 32'h43, 32'h0, 1'b1, 32'h0000DEAD, 1'b0, 2);
`endif
        drain();
        check("misalign_no_write", we_cnt - w0, 0);

        // invalid funct3
        w0 = we_cnt;
        request(1'b0, 3'b011, 32'h44, 32'h0, 1'b1, 32'h0, 1'b0, 1);
        request(1'b0, 3'b111, 32'h44, 32'h0, 1'b1, 32'h0, 1'b0, 1);
        request(1'b1, 3'b011, 32'h44, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1);
        request(1'b1, 3'b100, 32'h44, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1);
        drain();
        check("invalid_no_write", we_cnt - w0, 0);
        check("invalid_mem_word", mem[8'h11], 32'hCAFEAB01);

        // reset during READ aborts SB
        w0 = we_cnt;
        request(1'b1, 3'b000, 32'h44, 32'h00000055, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_read_ready", {31'h0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_read_no_write", we_cnt - w0, 0);
        check("rst_read_mem_word", mem[8'h11], 32'hCAFEAB01);

        // reset in WRITE still commits
        w0 = we_cnt;
        request(1'b1, 3'b010, 32'h48, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 0);
        #1;
        check("write_state_we", {31'h0, mem_we}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_write_we_count", we_cnt - w0, 1);
        check("rst_write_mem_word", mem[8'h12], 32'hA5A5A5A5);

        // reset beats a simultaneous request
        w0 = we_cnt;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_prio_ready", {31'h0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_prio_no_write", we_cnt - w0, 0);
        check("rst_prio_mem_word", mem[8'h10], 32'hDEADBEEF);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0x%08h exp=0x%08h", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports, as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, core request.
- req_ready, out, 1, unit idle; a request is accepted when req_valid && req_ready.
- req_store, in, 1, 1=store, 0=load.
- req_funct3, in, 3, RV32I width code (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010).
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data (low bits used for SB/SH).
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, 32, extended load result; 0 for stores.
- rsp_misalign, out, 1, misaligned-access flag, valid with rsp_valid.
- mem_we, out, 1, data-memory write enable.
- mem_wd, out, 32, data-memory write word.
- mem_a, out, 32, data-memory word index.
- mem_rd, in, 32, data-memory read word (combinational, same cycle as mem_a).

Function
REQ-003 SHALL use FSM states IDLE, READ, WRITE, RESP.
REQ-004 IDLE: req_ready=1; on accept, capture addr/funct3/store/wdata. Next state: loads and SB/SH -> READ; SW -> WRITE; invalid funct3 -> RESP.
REQ-005 mem_a SHALL equal {2'b00, captured_addr[31:2]} in READ and WRITE, and 0 elsewhere.
REQ-006 READ: register mem_rd. Loads -> RESP; SB/SH -> WRITE.
REQ-007 WRITE: mem_we=1 for exactly one cycle. mem_wd = req_wdata for SW, or the read word with the byte (addr[1:0]) / halfword (addr[1]) lane replaced for SB/SH. Next state -> RESP.
REQ-008 RESP: rsp_valid=1 for one cycle, then IDLE; req_ready=0 in READ, WRITE and RESP.
REQ-009 Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word; lane chosen by addr[1:0].
REQ-010 Latency from accept edge to rsp_valid: loads 2 cycles, SW 2, SB/SH 3, invalid/misaligned 1.
REQ-011 Invalid funct3 (load 011/110/111, store >=011) SHALL produce no memory write, with rsp_rdata=0 and rsp_misalign=0.
REQ-012 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-013 rst SHALL force IDLE on the next edge, with rsp_valid=0, rsp_rdata=0, rsp_misalign=0, mem_we=0, mem_wd=0, mem_a=0, and req_ready=1 after reset.
REQ-014 rst during READ SHALL abort the operation with no memory write.
REQ-015 rst asserted in WRITE SHALL still let that edge's write commit; no response is issued.
REQ-016 rst SHALL take priority over a simultaneous req_valid, and that request is not accepted.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN, defined:
- halfword with addr[0]=1, or word with addr[1:0]!=0 -> RESP directly.
- In that case: rsp_misalign=1, rsp_rdata=0, no memory access.
REQ-018 LSU_MISALIGN_TRAP_EN undefined:
- rsp_misalign tied 0.
- Halfword ignores addr[0]; word ignores addr[1:0].
- Normal access proceeds.

Structure
REQ-019 Package lsu_pkg SHALL hold funct3 constants, the FSM state enum, and the 2-bit lane type.
REQ-020 Sub-module lsu_align (combinational) SHALL do load extraction/extension and store lane merge; the FSM stays in load_store_unit.

Verification
REQ-021 Memory word 0x11 holds 0x80FF7F01; LB addr 0x46 -> rsp_rdata 0xFFFFFFFF, 2 cycles, mem_we never 1.
REQ-022 Same word; LHU addr 0x46 -> 0x000080FF; LH addr 0x46 -> 0xFFFF80FF.
REQ-023 Word 0x11 holds 0x80FF7F01; SB addr 0x45 wdata 0xAB -> single mem_we pulse, mem_a 0x11, mem_wd 0x80FFAB01, rsp_valid 3 cycles after accept.
REQ-024 SW addr 0x40 wdata 0xDEADBEEF -> mem_we in cycle 1, mem_wd 0xDEADBEEF, rsp_valid in cycle 2.
REQ-025 LW addr 0x42:
- With LSU_MISALIGN_TRAP_EN -> rsp_misalign=1, 1 cycle, no memory read.
- Without the macro -> full word at index 0x10.
REQ-026 SB accepted, rst asserted in READ -> no mem_we, no rsp_valid, req_ready=1 next cycle, memory unchanged.
